// File: rtl/fc_input_deserializer.sv
// Pops words from a first-word-fall-through FIFO and packs LAYER_HEIGHT of
// them into one parallel vector offered downstream on a valid/yumi handshake.
module fc_input_deserializer #(
    parameter int LAYER_HEIGHT = 256,
    parameter int WORD_SIZE    = 16,
    localparam int CW          = $clog2(LAYER_HEIGHT + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [WORD_SIZE-1:0]                   data_i,
    input  logic                                   empty_i,
    output logic                                   ren_o,
    output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o,
    output logic                                   valid_o,
    input  logic                                   yumi_i,
    output logic [CW-1:0]                          count_o
);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t                                 state;
    logic [CW-1:0]                          count;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data;
    logic                                   valid;
    logic                                   pop;

    // Pop only while collecting; a pending vector blocks the FIFO.
    assign pop     = reset_i & ~empty_i & (state == FILL);
    assign ren_o   = pop;
    assign data_o  = data;
    assign valid_o = valid;
    assign count_o = count;

    // Fill/hold state machine with registered valid, count and vector.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= FILL;
            count <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (pop) begin
                        for (int i = 0; i < LAYER_HEIGHT; i++) begin
                            if (count == CW'(i)) begin
                                data[i] <= data_i;
                            end
                        end
                        count <= count + CW'(1);
                        if (count == CW'(LAYER_HEIGHT - 1)) begin
                            state <= FULL;
                            valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (yumi_i) begin
                        state <= FILL;
                        valid <= 1'b0;
                        count <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_input_deserializer.sv
// Scoreboard bench for fc_input_deserializer: a queue-backed FIFO model
// feeds the DUT and a monitor compares each presented vector.
module tb_fc_input_deserializer;

    typedef logic [255:0][15:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] data_a;
    logic        empty_a;
    logic        ren_a;
    vec_t        vec_a;
    logic        valid_a;
    logic        yumi_a;
    logic [8:0]  cnt_a;

    logic [7:0]      data_b;
    logic            empty_b;
    logic            ren_b;
    logic [3:0][7:0] vec_b;
    logic            valid_b;
    logic            yumi_b;
    logic [2:0]      cnt_b;

    fc_input_deserializer #(
        .LAYER_HEIGHT(256),
        .WORD_SIZE   (16)
    ) dut_a (
        .clk_i  (clk),
        .reset_i(rst_n),
        .data_i (data_a),
        .empty_i(empty_a),
        .ren_o  (ren_a),
        .data_o (vec_a),
        .valid_o(valid_a),
        .yumi_i (yumi_a),
        .count_o(cnt_a)
    );

    fc_input_deserializer #(
        .LAYER_HEIGHT(4),
        .WORD_SIZE   (8)
    ) dut_b (
        .clk_i  (clk),
        .reset_i(rst_n),
        .data_i (data_b),
        .empty_i(empty_b),
        .ren_o  (ren_b),
        .data_o (vec_b),
        .valid_o(valid_b),
        .yumi_i (yumi_b),
        .count_o(cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] fifo_a[$];
    logic [7:0]  fifo_b[$];
    vec_t        exp_a[$];
    logic [31:0] exp_b[$];
    int          rises_a[$];

    int tests = 0;
    int fails = 0;
    int pops_a;
    int first_pop_a;
    int last_pop_a;
    int viol;
    bit gap_mode;
    bit gap_phase;
    bit stall;
    bit auto_yumi;
    bit yumi_man;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        data_a  = (fifo_a.size() != 0) ? fifo_a[0] : 16'h0;
        empty_a = (fifo_a.size() == 0) || stall || (gap_mode && gap_phase);
        data_b  = (fifo_b.size() != 0) ? fifo_b[0] : 8'h0;
        empty_b = (fifo_b.size() == 0);
        yumi_a  = yumi_man || (auto_yumi && valid_a);
        yumi_b  = 1'b0;
    endtask

    // One clock: sample pop strobes mid-cycle, retire popped words after the edge.
    task automatic cycle();
        logic ra, rb, ea, va;
        @(negedge clk);
        ra = ren_a;
        rb = ren_b;
        ea = empty_a;
        va = valid_a;
        if (ra && (ea || va)) viol++;
        @(posedge clk);
        #1;
        if (ra && fifo_a.size() != 0) begin
            void'(fifo_a.pop_front());
            pops_a++;
            if (pops_a == 1) first_pop_a = cyc;
            last_pop_a = cyc;
        end
        if (rb && fifo_b.size() != 0) void'(fifo_b.pop_front());
        gap_phase = ~gap_phase;
        drive();
    endtask

    task automatic load_a(input logic [15:0] base, input bit expect_it);
        vec_t v;
        for (int k = 0; k < 256; k++) begin
            fifo_a.push_back(base + 16'(k));
            v[k] = base + 16'(k);
        end
        if (expect_it) exp_a.push_back(v);
        drive();
    endtask

    task automatic wait_valid_a(input int budget, input string name);
        int n = 0;
        while (!valid_a && n < budget) begin
            cycle();
            n++;
        end
        check(valid_a, name, 64'(valid_a), 64'd1);
    endtask

    task automatic take_a();
        yumi_man = 1'b1;
        drive();
        cycle();
        yumi_man = 1'b0;
        drive();
        check(!valid_a, "take_valid_low", 64'(valid_a), 64'd0);
        check(cnt_a == 9'd0, "take_count_zero", 64'(cnt_a), 64'd0);
    endtask

    task automatic monitor_a();
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_a && !prev) begin
                rises_a.push_back(cyc);
                if (exp_a.size() == 0) begin
                    check(1'b0, "vec_a_unexpected", 64'd1, 64'd0);
                end else begin
                    vec_t e;
                    int   bad;
                    int   idx;
                    e   = exp_a.pop_front();
                    bad = 0;
                    idx = 0;
                    for (int k = 255; k >= 0; k--) begin
                        if (vec_a[k] !== e[k]) begin
                            bad++;
                            idx = k;
                        end
                    end
                    check(bad == 0, "vec_a_data", 64'(vec_a[idx]), 64'(e[idx]));
                    check(cnt_a == 9'd256, "vec_a_count", 64'(cnt_a), 64'd256);
                end
            end
            prev = valid_a;
        end
    endtask

    task automatic monitor_b();
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_b && !prev) begin
                if (exp_b.size() == 0) begin
                    check(1'b0, "vec_b_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_b.pop_front();
                    check(vec_b === e, "vec_b_data", 64'(vec_b), 64'(e));
                    check(cnt_b == 3'd4, "vec_b_count", 64'(cnt_b), 64'd4);
                end
            end
            prev = valid_b;
        end
    endtask

    initial begin
        vec_t snap;
        int   n;
        fork
            monitor_a();
            monitor_b();
        join_none

        rst_n     = 1'b0;
        gap_mode  = 1'b0;
        gap_phase = 1'b0;
        stall     = 1'b0;
        auto_yumi = 1'b0;
        yumi_man  = 1'b0;
        pops_a    = 0;
        viol      = 0;
        for (int k = 0; k < 4; k++) fifo_a.push_back(16'hEEEE);
        drive();

        #12;
        check(cnt_a == 9'd0, "rst_count", 64'(cnt_a), 64'd0);
        check(!valid_a, "rst_valid", 64'(valid_a), 64'd0);
        check(vec_a == '0, "rst_data", 64'(vec_a[0]), 64'd0);
        check(!ren_a, "rst_ren_blocked", 64'(ren_a), 64'd0);
        check(cnt_b == 3'd0, "rst_count_b", 64'(cnt_b), 64'd0);
        fifo_a.delete();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: continuous FIFO, vector held without yumi
        pops_a = 0;
        load_a(16'h0000, 1'b1);
        for (int k = 0; k < 8; k++) fifo_a.push_back(16'hEEEE);
        drive();
        wait_valid_a(400, "t1_valid");
        check(pops_a == 256, "t1_pops", 64'(pops_a), 64'd256);
        check(last_pop_a - first_pop_a == 255, "t1_consecutive",
              64'(last_pop_a - first_pop_a), 64'd255);
        repeat (10) cycle();
        check(pops_a == 256, "t1_no_pop_full", 64'(pops_a), 64'd256);
        check(valid_a, "t1_valid_held", 64'(valid_a), 64'd1);
        fifo_a.delete();
        drive();
        take_a();

        // 2: FIFO empty every other cycle
        pops_a    = 0;
        viol      = 0;
        gap_mode  = 1'b1;
        load_a(16'h4000, 1'b1);
        wait_valid_a(800, "t2_valid");
        take_a();
        gap_mode = 1'b0;
        drive();
        check(rises_a[$] == last_pop_a, "t2_latency",
              64'(rises_a[$] - last_pop_a), 64'd0);
        check(viol == 0, "t2_no_pop_empty", 64'(viol), 64'd0);
        check(pops_a == 256, "t2_pops", 64'(pops_a), 64'd256);

        // 3: yumi while not valid is ignored
        pops_a = 0;
        load_a(16'h5000, 1'b1);
        n = 0;
        while (pops_a < 50 && n < 200) begin
            cycle();
            n++;
        end
        stall = 1'b1;
        drive();
        cycle();
        snap     = vec_a;
        yumi_man = 1'b1;
        drive();
        cycle();
        cycle();
        yumi_man = 1'b0;
        drive();
        check(cnt_a == 9'd50, "t3_count_kept", 64'(cnt_a), 64'd50);
        check(vec_a == snap, "t3_data_kept", 64'(vec_a[49]), 64'(snap[49]));
        check(!valid_a, "t3_valid_low", 64'(valid_a), 64'd0);
        stall = 1'b0;
        drive();
        wait_valid_a(400, "t3_valid");
        take_a();

        // 4: back-to-back vectors with immediate yumi
        pops_a = 0;
        viol   = 0;
        load_a(16'h1000, 1'b1);
        load_a(16'h2000, 1'b1);
        auto_yumi = 1'b1;
        drive();
        n = 0;
        while (exp_a.size() != 0 && n < 800) begin
            cycle();
            n++;
        end
        cycle();
        auto_yumi = 1'b0;
        drive();
        check(exp_a.size() == 0, "t4_done", 64'(exp_a.size()), 64'd0);
        check(rises_a[$] - rises_a[$-1] == 257, "t4_spacing",
              64'(rises_a[$] - rises_a[$-1]), 64'd257);
        check(pops_a == 512, "t4_pops", 64'(pops_a), 64'd512);
        check(viol == 0, "t4_no_pop_on_yumi", 64'(viol), 64'd0);
        check(!valid_a, "t4_valid_low", 64'(valid_a), 64'd0);

        // 5: asynchronous reset mid-fill
        pops_a = 0;
        load_a(16'h6000, 1'b0);
        n = 0;
        while (pops_a < 100 && n < 300) begin
            cycle();
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check(cnt_a == 9'd0, "t5_async_count", 64'(cnt_a), 64'd0);
        check(!valid_a, "t5_async_valid", 64'(valid_a), 64'd0);
        check(!ren_a, "t5_async_ren", 64'(ren_a), 64'd0);
        cycle();
        rst_n = 1'b1;
        fifo_a.delete();
        pops_a = 0;
        load_a(16'h7000, 1'b1);
        wait_valid_a(400, "t5_valid");
        take_a();
        check(pops_a == 256, "t5_pops", 64'(pops_a), 64'd256);

        // 6: small instance byte packing
        fifo_b.push_back(8'hA1);
        fifo_b.push_back(8'hB2);
        fifo_b.push_back(8'hC3);
        fifo_b.push_back(8'hD4);
        exp_b.push_back(32'hD4C3B2A1);
        drive();
        n = 0;
        while (!valid_b && n < 20) begin
            cycle();
            n++;
        end
        check(valid_b, "t6_valid", 64'(valid_b), 64'd1);
        cycle();
        check(exp_b.size() == 0, "t6_checked", 64'(exp_b.size()), 64'd0);

        check(exp_a.size() == 0, "scoreboard_drained", 64'(exp_a.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
